// File: rtl/button_conditioner.sv
// Five-button front end: per-bit polarity fix, two-flop synchroniser, debounce,
// press-edge pulse and optional hold-to-repeat for up/down stepping.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter logic [4:0]  INVERT_MASK     = 5'b00011,
  parameter logic [4:0]  REPEAT_MASK     = 5'b00011
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_repeat
);

  localparam int unsigned NB   = 5;
  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] level_q, level_d;
  logic [NB-1:0] press_q, press_d;
  logic [NB-1:0] repeat_q, repeat_d;
  logic [NB-1:0] tick_c;
  logic [DW-1:0] deb_cnt_q [NB];
  logic [DW-1:0] deb_cnt_d [NB];
  logic [RW-1:0] rpt_cnt_q [NB];
  logic [RW-1:0] rpt_cnt_d [NB];
  rpt_state_e    state_q   [NB];
  rpt_state_e    state_d   [NB];

  // Debounce: level follows the synchronised input only after an unbroken disagreement run.
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      deb_cnt_d[i] = '0;
      level_d[i]   = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign press_d = level_d & ~level_q;

  // Repeat timer counts cycles since the press (DELAY) or since the last tick (REPEAT).
  always_comb begin
    tick_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!level_d[i]) begin
        state_d[i]   = ST_IDLE;
        rpt_cnt_d[i] = '0;
      end else if (press_d[i]) begin
        state_d[i]   = ST_DELAY;
        rpt_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_DELAY: begin
            if (rpt_cnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
              state_d[i]   = ST_REPEAT;
              rpt_cnt_d[i] = '0;
              tick_c[i]    = 1'b1;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == RW'(REPEAT_RATE - 1)) begin
              rpt_cnt_d[i] = '0;
              tick_c[i]    = 1'b1;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  assign repeat_d = press_d | (tick_c & REPEAT_MASK);

  always_ff @(posedge clk100) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      repeat_q <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        deb_cnt_q[i] <= '0;
        rpt_cnt_q[i] <= '0;
        state_q[i]   <= ST_IDLE;
      end
    end else begin
      sync1_q  <= btn_raw ^ INVERT_MASK;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      repeat_q <= repeat_d;
      for (int unsigned i = 0; i < NB; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  assign btn_level  = level_q;
  assign btn_press  = press_q;
  assign btn_repeat = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing inputs,
// compared every cycle against a window-based reference model.
module tb_button_conditioner;

  localparam int         DEB   = 4;
  localparam int         RD    = 10;
  localparam int         RR    = 3;
  localparam logic [4:0] RMASK = 5'b00011;
  localparam logic [4:0] INV_B = 5'b00011;

  logic       clk100 = 1'b0;
  logic       rst;
  logic [4:0] raw_a, raw_b;
  logic [4:0] lvl_a, press_a, rep_a;
  logic [4:0] lvl_b, press_b, rep_b;

  always #5 clk100 = ~clk100;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .INVERT_MASK(5'b00000), .REPEAT_MASK(RMASK)
  ) dut_a (
    .clk100(clk100), .rst(rst), .btn_raw(raw_a),
    .btn_level(lvl_a), .btn_press(press_a), .btn_repeat(rep_a)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .INVERT_MASK(INV_B), .REPEAT_MASK(RMASK)
  ) dut_b (
    .clk100(clk100), .rst(rst), .btn_raw(raw_b),
    .btn_level(lvl_b), .btn_press(press_b), .btn_repeat(rep_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a level flips when the last DEB synchronised samples all disagree with it;
  // repeat pulses are placed arithmetically relative to the press cycle.
  logic [4:0] m_s1 [2];
  logic [4:0] m_s2 [2];
  logic [4:0] m_lvl [2];
  logic [4:0] e_press [2];
  logic [4:0] e_rep [2];
  logic       m_hist [2][5][DEB];
  int         m_h [2][5];

  always @(posedge clk100) begin
    logic [4:0] rv, sv, nl, inv;
    bit         all_diff;
    int         age;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      rv  = (m == 0) ? raw_a : raw_b;
      inv = (m == 0) ? 5'b00000 : INV_B;
      if (rst) begin
        m_s1[m] = '0; m_s2[m] = '0; m_lvl[m] = '0;
        e_press[m] = '0; e_rep[m] = '0;
        for (int b = 0; b < 5; b++) begin
          m_h[m][b] = 0;
          for (int k = 0; k < DEB; k++) m_hist[m][b][k] = 1'b0;
        end
      end else begin
        sv = m_s2[m];
        m_s2[m] = m_s1[m];
        m_s1[m] = rv ^ inv;
        for (int b = 0; b < 5; b++) begin
          for (int k = DEB - 1; k > 0; k--) m_hist[m][b][k] = m_hist[m][b][k-1];
          m_hist[m][b][0] = sv[b];
          all_diff = 1'b1;
          for (int k = 0; k < DEB; k++) if (m_hist[m][b][k] == m_lvl[m][b]) all_diff = 1'b0;
          nl[b] = all_diff ? ~m_lvl[m][b] : m_lvl[m][b];
        end
        e_press[m] = nl & ~m_lvl[m];
        for (int b = 0; b < 5; b++) begin
          if (e_press[m][b]) m_h[m][b] = cyc;
          age = cyc - m_h[m][b];
          e_rep[m][b] = e_press[m][b] |
                        (RMASK[b] & nl[b] & (age >= RD) & (((age - RD) % RR) == 0));
        end
        m_lvl[m] = nl;
      end
    end
  end

  // Per-cycle model comparison plus event bookkeeping for the directed scenarios.
  int         press_cnt [5];
  int         rep_cnt [5];
  int         rise_cyc [5];
  int         rep_q [$];
  int         rise_b0;
  int         press_cnt_b;
  logic [4:0] lvl_prev_a = '0;
  logic       lvl_prev_b0 = 1'b0;

  always @(negedge clk100) begin
    if (chk_en) begin
      check("level_a", lvl_a, m_lvl[0]);
      check("press_a", press_a, e_press[0]);
      check("repeat_a", rep_a, e_rep[0]);
      check("level_b", lvl_b, m_lvl[1]);
      check("press_b", press_b, e_press[1]);
      check("repeat_b", rep_b, e_rep[1]);
    end
    for (int b = 0; b < 5; b++) begin
      if (press_a[b] === 1'b1) press_cnt[b]++;
      if (rep_a[b] === 1'b1) rep_cnt[b]++;
      if (lvl_a[b] === 1'b1 && lvl_prev_a[b] === 1'b0 && rise_cyc[b] < 0) rise_cyc[b] = cyc;
    end
    if (rep_a[0] === 1'b1) rep_q.push_back(cyc);
    if (press_b != 5'b00000) press_cnt_b++;
    if (lvl_b[0] === 1'b1 && lvl_prev_b0 === 1'b0 && rise_b0 < 0) rise_b0 = cyc;
    lvl_prev_a  = lvl_a;
    lvl_prev_b0 = lvl_b[0];
  end

  task automatic clear_obs();
    for (int b = 0; b < 5; b++) begin
      press_cnt[b] = 0; rep_cnt[b] = 0; rise_cyc[b] = -1;
    end
    rep_q.delete();
    rise_b0 = -1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk100);
      #2;
    end
  endtask

  function automatic int rq(input int i);
    return (i < rep_q.size()) ? rep_q[i] : -1000;
  endfunction

  function automatic int pick_len();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(8, 45));
  endfunction

  int t0, h;
  int rem_a [5];
  int rem_b [5];

  initial begin
    rst = 1'b1; raw_a = '0; raw_b = INV_B;
    press_cnt_b = 0;
    clear_obs();
    run(3);
    chk_en = 1'b1;
    check("rst_level", lvl_a, 0);
    check("rst_press", press_a, 0);
    check("rst_repeat", rep_a, 0);
    rst = 1'b0;
    run(8);

    // Single press on a non-repeating button
    clear_obs();
    raw_a[2] = 1'b1; t0 = cyc + 1;
    run(25);
    check("r25_latency", rise_cyc[2] - t0, 5);
    check("r25_press_cnt", press_cnt[2], 1);
    check("r25_repeat_cnt", rep_cnt[2], 1);
    raw_a[2] = 1'b0;
    run(15);

    // Held repeating button
    clear_obs();
    raw_a[0] = 1'b1; t0 = cyc + 1;
    run(32);
    check("r26_rep0", rq(0) - t0, 5);
    check("r26_rep1", rq(1) - t0, 15);
    check("r26_rep2", rq(2) - t0, 18);
    check("r26_rep3", rq(3) - t0, 21);
    check("r26_press_cnt", press_cnt[0], 1);
    raw_a[0] = 1'b0;
    run(15);

    // Short pulse rejected
    clear_obs();
    raw_a[1] = 1'b1; run(3); raw_a[1] = 1'b0;
    run(15);
    check("r27_press_cnt", press_cnt[1], 0);
    check("r27_no_level", rise_cyc[1], -1);

    // Bounce then settle
    clear_obs();
    raw_a[3] = 1'b1; run(2); raw_a[3] = 1'b0; run(2);
    raw_a[3] = 1'b1; run(2); raw_a[3] = 1'b0; run(2);
    raw_a[3] = 1'b1; t0 = cyc + 1;
    run(15);
    check("r28_latency", rise_cyc[3] - t0, 5);
    check("r28_press_cnt", press_cnt[3], 1);
    raw_a[3] = 1'b0;
    run(15);

    // Reset in the middle of a hold
    clear_obs();
    raw_a[0] = 1'b1;
    for (int k = 0; k < 20 && rise_cyc[0] < 0; k++) run(1);
    check("r29_rise_seen", rise_cyc[0] >= 0, 1);
    h = rise_cyc[0];
    run(h + 10 - cyc);
    rst = 1'b1; run(1); rst = 1'b0;
    check("r29_rst_level", lvl_a, 0);
    check("r29_rst_press", press_a, 0);
    check("r29_rst_repeat", rep_a, 0);
    clear_obs();
    run(15);
    check("r29_relatency", rise_cyc[0] - (h + 11), 6);
    raw_a[0] = 1'b0;
    run(15);

    // Active-low inputs idle high, then a press by pulling low
    check("r30_idle_press", press_cnt_b, 0);
    check("r30_idle_level", lvl_b, 0);
    clear_obs();
    raw_b[0] = 1'b0; t0 = cyc + 1;
    run(12);
    check("r30_latency", rise_b0 - t0, 5);
    raw_b[0] = 1'b1;
    run(15);

    // Random bouncing on all bits of both instances with occasional resets
    for (int b = 0; b < 5; b++) begin
      rem_a[b] = pick_len();
      rem_b[b] = pick_len();
    end
    repeat (4000) begin
      for (int b = 0; b < 5; b++) begin
        if (rem_a[b] == 0) begin raw_a[b] = ~raw_a[b]; rem_a[b] = pick_len(); end
        else rem_a[b]--;
        if (rem_b[b] == 0) begin raw_b[b] = ~raw_b[b]; rem_b[b] = pick_len(); end
        else rem_b[b]--;
      end
      rst = ($urandom_range(0, 499) == 0);
      run(1);
    end
    rst = 1'b0;
    run(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
